// File: rtl/imm_extend_pipe.sv
// Registered immediate extender for the decode stage: five extension modes,
// valid/ready handshake with a one-entry skid buffer, illegal-select flag.
package imm_extend_pkg;
  typedef enum logic [2:0] {
    IMM_ZX8    = 3'b000,
    IMM_ZX12   = 3'b001,
    IMM_BRANCH = 3'b010,
    IMM_SX12   = 3'b011,
    IMM_ROT8   = 3'b100
  } imm_sel_e;
endpackage

module imm_extend_pipe
  import imm_extend_pkg::*;
#(
  parameter int INSTR_W  = 24,
  parameter int DATA_W   = 48,
  parameter int BR_SHIFT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INSTR_W-1:0] Instr,
  input  logic [2:0]        ImmSrc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ExtImm,
  output logic              ImmErr
);

  logic [DATA_W-1:0] zx8;
  logic [DATA_W-1:0] sx_instr;
  logic [4:0]        rot_amt;
  logic [DATA_W-1:0] ext_next;
  logic              err_next;

  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic              main_err;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic              skid_err;

  logic in_fire;
  logic main_free;

  assign zx8      = {{(DATA_W-8){1'b0}}, Instr[7:0]};
  assign sx_instr = {{(DATA_W-INSTR_W){Instr[INSTR_W-1]}}, Instr};
  assign rot_amt  = {Instr[11:8], 1'b0};

  // Rotation wraps across the full DATA_W; a zero amount makes the left
  // shift span the whole width, which yields zero and leaves the plain imm8.
  always_comb begin
    ext_next = '0;
    err_next = 1'b0;
    case (ImmSrc)
      IMM_ZX8:    ext_next = zx8;
      IMM_ZX12:   ext_next = {{(DATA_W-12){1'b0}}, Instr[11:0]};
      IMM_BRANCH: ext_next = sx_instr << BR_SHIFT;
      IMM_SX12:   ext_next = {{(DATA_W-12){Instr[11]}}, Instr[11:0]};
      IMM_ROT8:   ext_next = (zx8 >> rot_amt) | (zx8 << (DATA_W - int'(rot_amt)));
      default:    err_next = 1'b1;
    endcase
  end

  assign in_ready  = !skid_valid;
  assign in_fire   = in_valid && in_ready;
  assign main_free = !main_valid || out_ready;

  assign out_valid = main_valid;
  assign ExtImm    = main_data;
  assign ImmErr    = main_err;

  // NOTE: every state element uses non-blocking assignment so all registers
  // update from the same pre-edge values; data is only cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_err   <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_err   <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_data  <= skid_data;
        main_err   <= skid_err;
        skid_valid <= 1'b0;
      end else if (in_fire) begin
        main_valid <= 1'b1;
        main_data  <= ext_next;
        main_err   <= err_next;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (in_fire) begin
      // Main is held by the consumer: park the new result in the skid entry.
      skid_valid <= 1'b1;
      skid_data  <= ext_next;
      skid_err   <= err_next;
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe with a scoreboard queue fed on input
// transfers and drained on output transfers.
module tb_imm_extend_pipe;

  localparam int IW = 24;
  localparam int DW = 48;
  localparam int BS = 2;

  typedef struct {
    logic [DW-1:0] ext;
    logic          err;
  } exp_t;

  typedef struct {
    logic [2:0]    src;
    logic [IW-1:0] ins;
    logic [DW-1:0] ext;
    logic          err;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] Instr = '0;
  logic [2:0]    ImmSrc = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] ExtImm;
  logic          ImmErr;

  int   errors = 0;
  int   checks = 0;
  int   pops = 0;
  bit   mon_en = 1'b0;
  exp_t sb[$];

  imm_extend_pipe #(.INSTR_W(IW), .DATA_W(DW), .BR_SHIFT(BS)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .Instr(Instr), .ImmSrc(ImmSrc),
    .out_valid(out_valid), .out_ready(out_ready),
    .ExtImm(ExtImm), .ImmErr(ImmErr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [IW-1:0] ins, input logic [2:0] src);
    exp_t          r;
    logic [DW-1:0] z;
    int            amt;
    r.ext = '0;
    r.err = 1'b0;
    case (src)
      3'b000: r.ext = {40'd0, ins[7:0]};
      3'b001: r.ext = {36'd0, ins[11:0]};
      3'b010: begin
        z = {{(DW-IW){ins[IW-1]}}, ins};
        r.ext = {z[DW-1-BS:0], {BS{1'b0}}};
      end
      3'b011: r.ext = {{36{ins[11]}}, ins[11:0]};
      3'b100: begin
        z = {40'd0, ins[7:0]};
        amt = 2 * int'(ins[11:8]);
        for (int i = 0; i < DW; i++) r.ext[i] = z[(i + amt) % DW];
      end
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

  // Scoreboard monitor, sampling mid-cycle where inputs and outputs are settled.
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_output", out_valid, 1'b0);
        end else begin
          check("sb_ext", ExtImm, sb[0].ext);
          check("sb_err", ImmErr, sb[0].err);
          if (out_ready) begin
            void'(sb.pop_front());
            pops++;
          end
        end
      end else begin
        check("out_valid_known", out_valid, 1'b0);
      end
      if (!reset || flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back(model(Instr, ImmSrc));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [IW-1:0] ins, input logic [2:0] src);
    int   n;
    logic ok;
    n = 0;
    in_valid = 1'b1;
    Instr    = ins;
    ImmSrc   = src;
    do begin
      ok = in_ready;
      tick();
      n++;
    end while (!ok && n < 50);
    check("send_accept", ok, 1'b1);
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[$];
    int   pops_before;

    vecs.push_back('{3'b000, 24'hABCDEF, 48'h0000000000EF, 1'b0});
    vecs.push_back('{3'b001, 24'hABCDEF, 48'h000000000DEF, 1'b0});
    vecs.push_back('{3'b011, 24'h000800, 48'hFFFFFFFFF800, 1'b0});
    vecs.push_back('{3'b100, 24'h000F01, 48'h000000040000, 1'b0});
    vecs.push_back('{3'b100, 24'h000012, 48'h000000000012, 1'b0});
    vecs.push_back('{3'b100, 24'h000381, 48'h040000000002, 1'b0});
    vecs.push_back('{3'b010, 24'h000003, 48'h00000000000C, 1'b0});
    vecs.push_back('{3'b101, 24'h123456, 48'h000000000000, 1'b1});
    vecs.push_back('{3'b111, 24'hFFFFFF, 48'h000000000000, 1'b1});

    // Reset held low for two edges.
    repeat (2) tick();
    reset = 1'b1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_ext", ExtImm, 48'h0);
    check("rst_err", ImmErr, 1'b0);
    mon_en = 1'b1;

    // Single branch-offset transfer, one cycle latency.
    out_ready = 1'b1;
    send(24'h800001, 3'b010);
    check("t1_valid", out_valid, 1'b1);
    check("t1_ext", ExtImm, 48'hFFFFFE000004);
    check("t1_err", ImmErr, 1'b0);

    // Mode sweep streamed back-to-back with the consumer always ready.
    foreach (vecs[i]) begin
      send(vecs[i].ins, vecs[i].src);
      check($sformatf("sweep%0d_ext", i), ExtImm, vecs[i].ext);
      check($sformatf("sweep%0d_err", i), ImmErr, vecs[i].err);
    end

    send(24'hFFFFFF, 3'b110);
    check("illegal_valid", out_valid, 1'b1);
    check("illegal_ext", ExtImm, 48'h0);
    check("illegal_err", ImmErr, 1'b1);
    tick();
    check("idle_valid", out_valid, 1'b0);

    // Backpressure: A in main, B in skid, C held by the source.
    out_ready = 1'b0;
    pops_before = pops;
    send(24'h000123, 3'b001);
    send(24'h000381, 3'b100);
    check("bp_in_ready", in_ready, 1'b0);
    in_valid = 1'b1;
    Instr    = 24'h0007FF;
    ImmSrc   = 3'b011;
    repeat (3) begin
      tick();
      check("bp_in_ready_held", in_ready, 1'b0);
      check("bp_hold_a", ExtImm, 48'h000000000123);
      check("bp_hold_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    send(24'h0007FF, 3'b011);
    repeat (3) tick();
    check("bp_out_count", pops - pops_before, 3);
    check("bp_sb_empty", sb.size(), 0);

    // Flush with both entries full and an input offered.
    out_ready = 1'b0;
    send(24'h0000AA, 3'b000);
    send(24'h0000BB, 3'b000);
    check("fl_in_ready", in_ready, 1'b0);
    in_valid = 1'b1;
    Instr    = 24'h0000CC;
    ImmSrc   = 3'b000;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_out_valid", out_valid, 1'b0);
    check("fl_in_ready_after", in_ready, 1'b1);
    out_ready = 1'b1;
    repeat (3) begin
      tick();
      check("fl_quiet", out_valid, 1'b0);
    end

    // Flush coinciding with an accepted input discards it.
    in_valid = 1'b1;
    Instr    = 24'h0000DD;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_in_discard", out_valid, 1'b0);
    tick();
    check("fl_in_discard2", out_valid, 1'b0);

    // Reset while both entries are full.
    out_ready = 1'b0;
    send(24'h000011, 3'b001);
    send(24'h000022, 3'b001);
    check("rs_in_ready", in_ready, 1'b0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("rs_out_valid", out_valid, 1'b0);
    check("rs_in_ready_after", in_ready, 1'b1);
    check("rs_ext", ExtImm, 48'h0);
    check("rs_err", ImmErr, 1'b0);
    out_ready = 1'b1;
    repeat (3) begin
      tick();
      check("rs_quiet", out_valid, 1'b0);
    end

    // A transfer after the mid-stall reset still works.
    send(24'h000F01, 3'b100);
    check("post_rs_ext", ExtImm, 48'h000000040000);
    tick();
    check("final_sb_empty", sb.size(), 0);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Registered, flow-controlled immediate extender for the decode stage of the pipelined CPU.
- Takes the instruction immediate field plus an immediate-select code and produces a DATA_W-wide extended immediate one cycle later.
- Supports five extension modes, including signed-12 and rotated-imm8, which the current combinational extender lacks.
- Uses a valid/ready handshake with a one-entry skid buffer so decode stalls never drop or duplicate immediates.
- Flags illegal select codes.

Parameters:
- INSTR_W, 24, width of the instruction immediate field; minimum 12.
- DATA_W, 48, width of the extended immediate; must satisfy DATA_W >= INSTR_W + BR_SHIFT.
- BR_SHIFT, 2, left shift applied to branch offsets.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- flush  in  1  synchronous pipeline flush, active-high.
- in_valid  in  1  Instr/ImmSrc are valid.
- in_ready  out  1  block can accept an input this cycle.
- Instr  in  INSTR_W  instruction immediate field.
- ImmSrc  in  3  extension mode select.
- out_valid  out  1  ExtImm/ImmErr are valid.
- out_ready  in  1  consumer accepts the output this cycle.
- ExtImm  out  DATA_W  extended immediate.
- ImmErr  out  1  ImmSrc of the presented result was illegal.

Behaviour:
- Extension modes (combinational, computed on the input side):
  - 000: zero-extend Instr[7:0].
  - 001: zero-extend Instr[11:0].
  - 010: sign-extend Instr[INSTR_W-1:0], then shift left by BR_SHIFT (zeros in). The result is DATA_W wide.
  - 011: sign-extend Instr[11:0].
  - 100: zero-extend Instr[7:0] to DATA_W, then rotate right within DATA_W by 2*Instr[11:8], giving 0..30 bit positions.
  - 101, 110, 111: illegal. ExtImm = 0 and ImmErr = 1. Never X.
- Transfers:
  - Input transfer happens when in_valid && in_ready.
  - Output transfer happens when out_valid && out_ready.
- Storage is two entries: the output register (main) and a skid register (skid), each with a valid bit.
- in_ready = !skid_valid. It is a register output with no combinational path from out_ready.
- Latency: one cycle. An input accepted at edge N is presented at edge N+1 if main is empty or draining.
- Per-cycle update, evaluated at the edge:
  - main empty or draining, skid empty: an input transfer loads main. Otherwise main_valid clears if it drained.
  - main full and not draining, with an input transfer: the input loads skid and skid_valid is set, so in_ready drops next cycle.
  - main draining, skid full: skid moves into main and skid_valid clears. No input is accepted because in_ready = 0.
  - main full and held (out_ready = 0): main stays stable. ExtImm and ImmErr must not change while out_valid = 1 and out_ready = 0.
- Simultaneous drain and fill with main full and skid empty: main takes the new input, with no bubble.
- flush = 1:
  - At the edge, main_valid and skid_valid clear.
  - Any concurrent input transfer is discarded.
  - Next cycle out_valid = 0 and in_ready = 1.
  - Data registers may hold stale values.
- reset = 0 at an edge:
  - out_valid = 0, in_ready = 1, ExtImm = 0, ImmErr = 0, skid cleared.
  - Reset asserted mid-stall discards both entries.
  - reset has priority over flush, and flush has priority over transfers.
- Order is strictly FIFO. No entry is reordered, duplicated or dropped except by flush or reset.
- Rotate mode: a rotate amount of 0 returns the plain zero-extended imm8. Rotation wraps across DATA_W, not 32 bits.

Test Plan:
- Reset then single transfer:
  - After reset (0 for 2 cycles): out_valid = 0, in_ready = 1, ExtImm = 0.
  - Drive ImmSrc = 010, Instr = 0x800001, out_ready = 1.
  - Next cycle: ExtImm = 0xFFFFFE000004, ImmErr = 0.
- Mode sweep with DATA_W = 48:
  - 000 / Instr = 0xABCDEF → 0x0000000000EF.
  - 001 / 0xABCDEF → 0x000000000DEF.
  - 011 / 0x000800 → 0xFFFFFFFFF800.
  - 100 / 0x000F01 → 0x000000040000.
  - 100 / 0x000012 → 0x000000000012.
- Illegal mode: ImmSrc = 110, Instr = 0xFFFFFF → ExtImm = 0, ImmErr = 1, out_valid = 1.
- Backpressure:
  - Hold out_ready = 0 and stream A, B, C back-to-back.
  - A sits in main, B in skid, in_ready = 0, C held by the source.
  - Release out_ready: outputs arrive in order A, B, C with no drops, and ExtImm stays stable while stalled.
- Flush: with main and skid both full plus a concurrent input, assert flush for one cycle → next cycle out_valid = 0, in_ready = 1, and no entry is ever presented.
- Reset mid-stall: with both entries full, assert reset = 0 for one edge → out_valid = 0, in_ready = 1, ExtImm = 0, and no stale data appears after release.
